// File: rtl/rx_char_decoder_if.sv
// Bit-stream input and decoded-character output bundle of rx_char_decoder.
// The tick_o/time_o pair exists only when RX_TIMECODE_EN is defined.
interface rx_char_decoder_if;
  logic       rxd;
  logic       rxv;
  logic       gotnull_o;
  logic       nchar;
  logic       lchar;
  logic [7:0] char_o;
  logic       fct_o;
  logic       null_o;
`ifdef RX_TIMECODE_EN
  logic       tick_o;
  logic [7:0] time_o;
`endif
  logic       parity_err_o;
  logic       esc_err_o;

`ifdef RX_TIMECODE_EN
  modport master (
    output rxd, rxv,
    input  gotnull_o, nchar, lchar, char_o, fct_o, null_o,
    input  tick_o, time_o, parity_err_o, esc_err_o
  );
  modport slave (
    input  rxd, rxv,
    output gotnull_o, nchar, lchar, char_o, fct_o, null_o,
    output tick_o, time_o, parity_err_o, esc_err_o
  );
`else
  modport master (
    output rxd, rxv,
    input  gotnull_o, nchar, lchar, char_o, fct_o, null_o,
    input  parity_err_o, esc_err_o
  );
  modport slave (
    input  rxd, rxv,
    output gotnull_o, nchar, lchar, char_o, fct_o, null_o,
    output parity_err_o, esc_err_o
  );
`endif
endinterface

// File: rtl/rx_char_decoder.sv
// Link-layer receive character decoder: NULL acquisition, odd parity check, escape handling.
// Define RX_TIMECODE_EN to decode ESC+data as a time-code (tick_o/time_o) instead of an error.
module rx_char_decoder (
  input  logic             clk,
  input  logic             reset,
  rx_char_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    PAR  = 2'd1,
    FLAG = 2'd2,
    DATA = 2'd3
  } state_t;

  // Oldest bit first: ESC tail (F,1,1) followed by FCT (P,F,0,0).
  localparam logic [6:0] NULL_PAT = 7'b1110100;
  localparam logic [1:0] CODE_FCT = 2'd0;
  localparam logic [1:0] CODE_EOP = 2'd1;
  localparam logic [1:0] CODE_EEP = 2'd2;
  localparam logic [1:0] CODE_ESC = 2'd3;

  function automatic logic odd_parity_ok(input logic prev, input logic p, input logic f);
    return (prev ^ p ^ f) == 1'b1;
  endfunction

  function automatic logic xor8(input logic [7:0] v);
    return ^v;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] win_q, win_d;
  logic [6:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic       ctrl_q, ctrl_d;
  logic       prev_q, prev_d;
  logic       esc_q, esc_d;
  logic       gotnull_q, gotnull_d;
  logic       nchar_q, nchar_d;
  logic       lchar_q, lchar_d;
  logic [7:0] char_q, char_d;
  logic       fct_q, fct_d;
  logic       null_q, null_d;
  logic       perr_q, perr_d;
  logic       eerr_q, eerr_d;
`ifdef RX_TIMECODE_EN
  logic       tick_q, tick_d;
  logic [7:0] time_q, time_d;
`endif
  logic       lose_s;
  logic [7:0] byte_s;
  logic [1:0] code_s;

  // Payload completed by the bit currently on rxd (LSB arrived first).
  assign byte_s = {bus.rxd, shift_q};
  assign code_s = {bus.rxd, shift_q[6]};

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT;
      win_q     <= 6'd0;
      shift_q   <= 7'd0;
      cnt_q     <= 4'd0;
      par_q     <= 1'b0;
      ctrl_q    <= 1'b0;
      prev_q    <= 1'b0;
      esc_q     <= 1'b0;
      gotnull_q <= 1'b0;
      nchar_q   <= 1'b0;
      lchar_q   <= 1'b0;
      char_q    <= 8'h00;
      fct_q     <= 1'b0;
      null_q    <= 1'b0;
      perr_q    <= 1'b0;
      eerr_q    <= 1'b0;
`ifdef RX_TIMECODE_EN
      tick_q    <= 1'b0;
      time_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      ctrl_q    <= ctrl_d;
      prev_q    <= prev_d;
      esc_q     <= esc_d;
      gotnull_q <= gotnull_d;
      nchar_q   <= nchar_d;
      lchar_q   <= lchar_d;
      char_q    <= char_d;
      fct_q     <= fct_d;
      null_q    <= null_d;
      perr_q    <= perr_d;
      eerr_q    <= eerr_d;
`ifdef RX_TIMECODE_EN
      tick_q    <= tick_d;
      time_q    <= time_d;
`endif
    end
  end

  // Framing FSM, character dispatch and error recovery.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    ctrl_d    = ctrl_q;
    prev_d    = prev_q;
    esc_d     = esc_q;
    gotnull_d = gotnull_q;
    nchar_d   = 1'b0;
    lchar_d   = 1'b0;
    char_d    = char_q;
    fct_d     = 1'b0;
    null_d    = 1'b0;
    perr_d    = 1'b0;
    eerr_d    = 1'b0;
`ifdef RX_TIMECODE_EN
    tick_d    = 1'b0;
    time_d    = time_q;
`endif
    lose_s    = 1'b0;

    if (bus.rxv) begin
      case (state_q)
        HUNT: begin
          win_d = {win_q[4:0], bus.rxd};
          if ({win_q, bus.rxd} == NULL_PAT) begin
            gotnull_d = 1'b1;
            null_d    = 1'b1;
            prev_d    = 1'b0;
            esc_d     = 1'b0;
            win_d     = 6'd0;
            state_d   = PAR;
          end else begin
            state_d = HUNT;
          end
        end
        PAR: begin
          par_d   = bus.rxd;
          state_d = FLAG;
        end
        FLAG: begin
          ctrl_d = bus.rxd;
          if (!odd_parity_ok(prev_q, par_q, bus.rxd)) begin
            perr_d = 1'b1;
            lose_s = 1'b1;
          end else begin
            cnt_d   = bus.rxd ? 4'd2 : 4'd8;
            state_d = DATA;
          end
        end
        DATA: begin
          shift_d = byte_s[7:1];
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = PAR;
            esc_d   = 1'b0;
            if (ctrl_q) begin
              prev_d = code_s[1] ^ code_s[0];
            end else begin
              prev_d = xor8(byte_s);
            end
            if (!esc_q) begin
              if (!ctrl_q) begin
                nchar_d = 1'b1;
                char_d  = byte_s;
              end else begin
                case (code_s)
                  CODE_FCT: begin
                    lchar_d = 1'b1;
                    fct_d   = 1'b1;
                    char_d  = {6'd0, code_s};
                  end
                  CODE_EOP, CODE_EEP: begin
                    lchar_d = 1'b1;
                    char_d  = {6'd0, code_s};
                  end
                  CODE_ESC: esc_d = 1'b1;
                  default:  esc_d = 1'b0;
                endcase
              end
            end else if (ctrl_q) begin
              if (code_s == CODE_FCT) begin
                null_d = 1'b1;
              end else begin
                eerr_d = 1'b1;
                lose_s = 1'b1;
              end
            end else begin
`ifdef RX_TIMECODE_EN
              tick_d = 1'b1;
              time_d = byte_s;
`else
              eerr_d = 1'b1;
              lose_s = 1'b1;
`endif
            end
          end else begin
            state_d = DATA;
          end
        end
        default: state_d = HUNT;
      endcase
    end else begin
      state_d = state_q;
    end

    // Stale window bits are dropped so that reacquisition needs a complete fresh NULL.
    if (lose_s) begin
      state_d   = HUNT;
      gotnull_d = 1'b0;
      esc_d     = 1'b0;
      win_d     = 6'd0;
    end else begin
      gotnull_d = gotnull_d;
    end
  end

  assign bus.gotnull_o    = gotnull_q;
  assign bus.nchar        = nchar_q;
  assign bus.lchar        = lchar_q;
  assign bus.char_o       = char_q;
  assign bus.fct_o        = fct_q;
  assign bus.null_o       = null_q;
  assign bus.parity_err_o = perr_q;
  assign bus.esc_err_o    = eerr_q;
`ifdef RX_TIMECODE_EN
  assign bus.tick_o       = tick_q;
  assign bus.time_o       = time_q;
`endif

endmodule

// File: tb/tb_rx_char_decoder.sv
// Self-checking bench for rx_char_decoder: directed scenarios plus randomized character
// streams compared against a queue-based model of the character rules.
module tb_rx_char_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;

  rx_char_decoder_if bus();
  rx_char_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {gotnull, nchar, lchar, fct, null, perr, eerr, tick, char[7:0], time[7:0]}
  logic [23:0] obs;
`ifdef RX_TIMECODE_EN
  assign obs = {bus.gotnull_o, bus.nchar, bus.lchar, bus.fct_o, bus.null_o,
                bus.parity_err_o, bus.esc_err_o, bus.tick_o, bus.char_o, bus.time_o};
`else
  assign obs = {bus.gotnull_o, bus.nchar, bus.lchar, bus.fct_o, bus.null_o,
                bus.parity_err_o, bus.esc_err_o, 1'b0, bus.char_o, 8'h00};
`endif

  logic [23:0] q_act[$];
  logic [23:0] q_exp[$];

  // Reference model state: framing flag, bits of the character in flight, recent bits in HUNT.
  bit m_framed, m_esc, m_prev, m_got;
  bit [7:0] m_char, m_time;
  bit m_win[$];
  bit m_cb[$];
  logic [23:0] m_exp;
  bit tx_prev;
  bit gap_en;

  task automatic model_reset();
    m_framed = 0; m_esc = 0; m_prev = 0; m_got = 0;
    m_char = 8'h00; m_time = 8'h00;
    m_win.delete(); m_cb.delete();
  endtask

  task automatic model_lose();
    m_framed = 0; m_got = 0; m_esc = 0;
    m_cb.delete(); m_win.delete();
  endtask

  task automatic model_bit(input bit b);
    bit nch, lch, fct, nul, per, eer, tck;
    nch = 0; lch = 0; fct = 0; nul = 0; per = 0; eer = 0; tck = 0;
    if (!m_framed) begin
      m_win.push_back(b);
      if (m_win.size() > 7) void'(m_win.pop_front());
      if (m_win.size() == 7 && m_win[0] && m_win[1] && m_win[2] && !m_win[3] &&
          m_win[4] && !m_win[5] && !m_win[6]) begin
        m_framed = 1; m_got = 1; nul = 1; m_prev = 0; m_esc = 0;
        m_cb.delete(); m_win.delete();
      end
    end else begin
      m_cb.push_back(b);
      if (m_cb.size() == 2 && (m_prev ^ m_cb[0] ^ m_cb[1]) == 1'b0) begin
        per = 1;
        model_lose();
      end else if (m_cb.size() >= 4 && m_cb.size() == (m_cb[1] ? 4 : 10)) begin
        int unsigned val;
        bit px, ctrl;
        val = 0; px = 0; ctrl = m_cb[1];
        for (int i = 2; i < m_cb.size(); i++) begin
          val = val | (int'(m_cb[i]) << (i - 2));
          px  = px ^ m_cb[i];
        end
        m_cb.delete();
        m_prev = px;
        if (!m_esc) begin
          if (!ctrl) begin
            nch = 1; m_char = val[7:0];
          end else if (val == 0) begin
            lch = 1; fct = 1; m_char = 8'h00;
          end else if (val == 3) begin
            m_esc = 1;
          end else begin
            lch = 1; m_char = val[7:0];
          end
        end else begin
          m_esc = 0;
          if (ctrl && val == 0) nul = 1;
          else if (ctrl) begin eer = 1; model_lose(); end
          else begin
`ifdef RX_TIMECODE_EN
            tck = 1; m_time = val[7:0];
`else
            eer = 1; model_lose();
`endif
          end
        end
      end
    end
    m_exp = {m_got, nch, lch, fct, nul, per, eer, tck, m_char, m_time};
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    bus.rxd = b; bus.rxv = 1'b1;
    @(posedge clk); #1;
    model_bit(b);
    q_act.push_back(obs);
    q_exp.push_back(m_exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rxv = 1'b0; bus.rxd = 1'($urandom);
      @(posedge clk); #1;
      m_exp = {m_got, 7'd0, m_char, m_time};
      q_act.push_back(obs);
      q_exp.push_back(m_exp);
    end
  endtask

  task automatic send_vec(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic maybe_gap();
    if (gap_en && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
  endtask

  // Transmitter side: parity computed from its own record of the last payload sent.
  task automatic send_char(input bit ctrl, input logic [7:0] val, input bit bad);
    int n;
    n = ctrl ? 2 : 8;
    maybe_gap(); send_bit(1'b1 ^ tx_prev ^ ctrl ^ bad);
    maybe_gap(); send_bit(ctrl);
    for (int i = 0; i < n; i++) begin maybe_gap(); send_bit(val[i]); end
    tx_prev = ctrl ? (val[0] ^ val[1]) : ^val;
  endtask

  task automatic do_acquire();
    @(negedge clk); reset = 1'b1; bus.rxv = 1'b0;
    @(negedge clk); reset = 1'b0;
    model_reset();
    send_vec(16'b01110100, 8);
    tx_prev = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      reset = 1'b1; bus.rxv = i[0]; bus.rxd = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (obs !== 24'h0) begin errors++; $display("FAIL reset_hold obs=%h want=000000", obs); end
    end
    @(negedge clk); reset = 1'b0; bus.rxv = 1'b0;
    model_reset();
    send_vec(16'b111010, 6);
    // The completing NULL bit arrives together with reset and must be dropped.
    @(negedge clk); reset = 1'b1; bus.rxv = 1'b1; bus.rxd = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== 24'h0) begin errors++; $display("FAIL reset_rxv obs=%h want=000000", obs); end
    @(negedge clk); reset = 1'b0; bus.rxv = 1'b0;
    model_reset();
    foreach (q_act[i]) begin
      checks++;
      if (q_act[i] !== q_exp[i]) begin errors++; $display("FAIL reset step%0d obs=%h exp=%h", i, q_act[i], q_exp[i]); end
    end
    q_act.delete(); q_exp.delete();
  endtask

  task automatic test_acquisition();
    send_vec(16'b010, 3);
    send_vec(16'b01110100, 8);
    checks++;
    if (bus.null_o !== 1'b1 || bus.gotnull_o !== 1'b1)
      begin errors++; $display("FAIL acq_null null=%b gotnull=%b want 1 1", bus.null_o, bus.gotnull_o); end
    idle(1);
    tx_prev = 0;
    foreach (q_act[i]) begin
      checks++;
      if (q_act[i] !== q_exp[i]) begin errors++; $display("FAIL acq step%0d obs=%h exp=%h", i, q_act[i], q_exp[i]); end
    end
    q_act.delete(); q_exp.delete();
  endtask

  task automatic test_data();
    send_vec(16'b1010100101, 10);
    checks++;
    if (bus.nchar !== 1'b1 || bus.char_o !== 8'hA5)
      begin errors++; $display("FAIL data_a5 nchar=%b char=%h want 1 a5", bus.nchar, bus.char_o); end
    idle(1);
    foreach (q_act[i]) begin
      checks++;
      if (q_act[i] !== q_exp[i]) begin errors++; $display("FAIL data step%0d obs=%h exp=%h", i, q_act[i], q_exp[i]); end
    end
    q_act.delete(); q_exp.delete();
  endtask

  task automatic test_eop();
    send_vec(16'b0110, 4);
    checks++;
    if (bus.lchar !== 1'b1 || bus.char_o !== 8'h01 || bus.fct_o !== 1'b0)
      begin errors++; $display("FAIL eop lchar=%b char=%h fct=%b want 1 01 0", bus.lchar, bus.char_o, bus.fct_o); end
    idle(2);
    foreach (q_act[i]) begin
      checks++;
      if (q_act[i] !== q_exp[i]) begin errors++; $display("FAIL eop step%0d obs=%h exp=%h", i, q_act[i], q_exp[i]); end
    end
    q_act.delete(); q_exp.delete();
  endtask

  task automatic test_parity_error();
    do_acquire();
    send_bit(1'b0);
    send_bit(1'b0);
    checks++;
    if (bus.parity_err_o !== 1'b1 || bus.gotnull_o !== 1'b0)
      begin errors++; $display("FAIL parity_err perr=%b gotnull=%b want 1 0", bus.parity_err_o, bus.gotnull_o); end
    send_vec(16'b1010100101, 10);
    idle(2);
    foreach (q_act[i]) begin
      checks++;
      if (q_act[i] !== q_exp[i]) begin errors++; $display("FAIL parity step%0d obs=%h exp=%h", i, q_act[i], q_exp[i]); end
    end
    q_act.delete(); q_exp.delete();
  endtask

  task automatic test_timecode();
    do_acquire();
    send_char(1'b1, 8'd3, 1'b0);
    send_char(1'b0, 8'h3F, 1'b0);
    checks++;
`ifdef RX_TIMECODE_EN
    if (bus.tick_o !== 1'b1 || bus.time_o !== 8'h3F || bus.nchar !== 1'b0)
      begin errors++; $display("FAIL timecode tick=%b time=%h nchar=%b want 1 3f 0", bus.tick_o, bus.time_o, bus.nchar); end
`else
    if (bus.esc_err_o !== 1'b1 || bus.gotnull_o !== 1'b0)
      begin errors++; $display("FAIL timecode esc_err=%b gotnull=%b want 1 0", bus.esc_err_o, bus.gotnull_o); end
`endif
    idle(1);
    foreach (q_act[i]) begin
      checks++;
      if (q_act[i] !== q_exp[i]) begin errors++; $display("FAIL tcode step%0d obs=%h exp=%h", i, q_act[i], q_exp[i]); end
    end
    q_act.delete(); q_exp.delete();
  endtask

  task automatic test_mid_char_reset();
    do_acquire();
    send_vec(16'b100110, 6);
    @(negedge clk); reset = 1'b1; bus.rxv = 1'b1; bus.rxd = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 24'h0) begin errors++; $display("FAIL midreset obs=%h want=000000", obs); end
    @(negedge clk); reset = 1'b0; bus.rxv = 1'b0;
    model_reset();
    send_vec(16'b1010, 4);
    idle(1);
    foreach (q_act[i]) begin
      checks++;
      if (q_act[i] !== q_exp[i]) begin errors++; $display("FAIL midreset step%0d obs=%h exp=%h", i, q_act[i], q_exp[i]); end
    end
    q_act.delete(); q_exp.delete();
  endtask

  task automatic test_random_stream(input bit gaps, input int nchars);
    int r;
    gap_en = gaps;
    do_acquire();
    for (int k = 0; k < nchars; k++) begin
      if (!m_framed) begin
        send_char(1'b1, 8'd3, 1'b0);
        send_char(1'b1, 8'd0, 1'b0);
      end
      r = int'($urandom_range(0, 19));
      if (r < 10 || r > 17) send_char(1'b0, 8'($urandom), 1'b0);
      else if (r <= 12) send_char(1'b1, 8'(r - 10), 1'b0);
      else if (r == 13) begin send_char(1'b1, 8'd3, 1'b0); send_char(1'b1, 8'd0, 1'b0); end
      else if (r == 14) begin send_char(1'b1, 8'd3, 1'b0); send_char(1'b0, 8'($urandom), 1'b0); end
      else if (r == 15) begin send_char(1'b1, 8'd3, 1'b0); send_char(1'b1, 8'($urandom_range(1, 3)), 1'b0); end
      else if (r == 16) send_char(1'b0, 8'($urandom), 1'b1);
      else send_char(1'b1, 8'd3, 1'b0);
    end
    idle(2);
    gap_en = 0;
    foreach (q_act[i]) begin
      checks++;
      if (q_act[i] !== q_exp[i]) begin errors++; $display("FAIL stream%0d step%0d obs=%h exp=%h", gaps, i, q_act[i], q_exp[i]); end
    end
    q_act.delete(); q_exp.delete();
  endtask

  initial begin
    bus.rxd = 1'b0;
    bus.rxv = 1'b0;
    gap_en = 0;
    tx_prev = 0;
    model_reset();
    test_reset();
    test_acquisition();
    test_data();
    test_eop();
    test_parity_error();
    test_timecode();
    test_mid_char_reset();
    test_random_stream(1'b0, 200);
    test_random_stream(1'b1, 150);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog sim time exceeded checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
